// File: rtl/instr_encoder.sv
// LEGv8 program loader: encodes symbolic instructions into 32-bit words and
// streams them to instruction memory at consecutive word addresses.
module instr_encoder #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_instr,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [25:0]       in_imm,
    input  logic [1:0]        in_hw,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              err,
    output logic [CNT_W-1:0]  err_idx
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | accepting instructions until num_instr have been taken
    // DRAIN | final word waiting in the output register
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  acc_cnt;
    logic [31:0]       enc_word;
    logic              enc_err;
    logic              accept;
    logic              imm19_bad;
    logic              imm9_bad;
    logic              imm12_bad;
    logic              imm16_bad;

    assign busy     = (state != IDLE);
    assign in_ready = (state == RUN) && (acc_cnt < num_q) && (!wr_valid || wr_ready);
    assign accept   = in_valid && in_ready;

    // Signed fields fit when every bit above the field's sign bit matches it.
    assign imm19_bad = (in_imm[25:18] != {8{in_imm[18]}});
    assign imm9_bad  = (in_imm[25:8] != {18{in_imm[8]}});
    assign imm12_bad = (in_imm[25:12] != '0);
    assign imm16_bad = (in_imm[25:16] != '0);

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (in_op)
            4'd0:  enc_word = {6'b000101, in_imm};
            4'd1:  begin enc_word = {8'b10110100, in_imm[18:0], in_rd};    enc_err = imm19_bad; end
            4'd2:  begin enc_word = {8'b01010100, in_imm[18:0], 5'b01011}; enc_err = imm19_bad; end
            4'd3:  enc_word = {11'b10101011000, in_rm, 6'b000000, in_rn, in_rd};
            4'd4:  enc_word = {11'b11101011000, in_rm, 6'b000000, in_rn, in_rd};
            4'd5:  begin enc_word = {10'b1001000100, in_imm[11:0], in_rn, in_rd}; enc_err = imm12_bad; end
            4'd6:  begin enc_word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd}; enc_err = imm9_bad; end
            4'd7:  begin enc_word = {11'b00111000010, in_imm[8:0], 2'b00, in_rn, in_rd}; enc_err = imm9_bad; end
            4'd8:  begin enc_word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd}; enc_err = imm9_bad; end
            4'd9:  begin enc_word = {11'b00111000000, in_imm[8:0], 2'b00, in_rn, in_rd}; enc_err = imm9_bad; end
            4'd10: begin enc_word = {9'b111100101, in_hw, in_imm[15:0], in_rd}; enc_err = imm16_bad; end
            4'd11: begin enc_word = {9'b110100101, in_hw, in_imm[15:0], in_rd}; enc_err = imm16_bad; end
            default: enc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            acc_cnt  <= '0;
            done     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err      <= 1'b0;
            err_idx  <= '0;
        end else begin
            done <= 1'b0;
            if (wr_valid && wr_ready)
                wr_valid <= 1'b0;
            // A same-cycle drain and refill overrides the clear above, so no bubble.
            if (accept) begin
                wr_valid <= 1'b1;
                wr_data  <= enc_word;
                wr_addr  <= base_q + (ADDR_W'(acc_cnt) << 2);
                acc_cnt  <= acc_cnt + CNT_W'(1);
                if (enc_err && !err) begin
                    err     <= 1'b1;
                    err_idx <= acc_cnt;
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_addr & ~ADDR_W'(3);
                        num_q   <= num_instr;
                        acc_cnt <= '0;
                        err     <= 1'b0;
                        err_idx <= '0;
                        if (num_instr == '0)
                            done <= 1'b1;
                        else
                            state <= RUN;
                    end
                end
                RUN: begin
                    if (accept && (acc_cnt == num_q - CNT_W'(1)))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (wr_valid && wr_ready) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Program loader for the LEGv8 single-cycle CPU. It is the encoder counterpart to the main control decoder.
- It accepts symbolic instructions (op class plus register and immediate fields) over a valid/ready handshake and assembles 32-bit LEGv8 instruction words.
- It writes each word to the instruction memory write port at consecutive word addresses from a programmable base.
- Used by benches and boot logic to load programs without hand-built hex.

Parameters:
- ADDR_W, 64, width of the instruction memory byte address.
- CNT_W, 16, width of the instruction count and index.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load job; sampled only in IDLE.
- base_addr  input  ADDR_W  byte address of the first word; captured on start; bits [1:0] forced to 0.
- num_instr  input  CNT_W  number of instructions in the job; captured on start.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse when the job completes.
- in_valid  input  1  source has an instruction.
- in_ready  output  1  encoder accepts the instruction this cycle.
- in_op  input  4  op code: 0 B, 1 CBZ, 2 B_LT, 3 ADDS, 4 SUBS, 5 ADDI, 6 LDUR, 7 LDURB, 8 STUR, 9 STURB, 10 MOVK, 11 MOVZ, 12-15 illegal.
- in_rd  input  5  Rd or Rt.
- in_rn  input  5  Rn.
- in_rm  input  5  Rm.
- in_imm  input  26  immediate; two's complement for B/CBZ/B_LT/LDUR*/STUR*, unsigned otherwise.
- in_hw  input  2  MOVK/MOVZ shift field.
- wr_valid  output  1  write request to instruction memory.
- wr_ready  input  1  memory accepts the write.
- wr_addr  output  ADDR_W  byte address of the write.
- wr_data  output  32  encoded instruction.
- err  output  1  sticky; an illegal op or out-of-range immediate was seen this job.
- err_idx  output  CNT_W  index (0-based) of the first erroneous instruction.

Behaviour:
- Reset values: busy=0, done=0, in_ready=0, wr_valid=0, wr_addr=0, wr_data=0, err=0, err_idx=0. The FSM resets to IDLE.
- Reset mid-job aborts immediately. There is no write after reset deasserts.
- FSM states are IDLE, RUN and DRAIN.
- IDLE:
  - On start, capture base_addr and num_instr, set accepted count to 0, and clear err and err_idx.
  - Go to RUN if num_instr!=0.
  - If num_instr==0, pulse done the next cycle and stay in IDLE.
- RUN:
  - in_ready = (accepted < num_instr) && (!wr_valid || wr_ready).
  - On in_valid && in_ready, register the encoded word. wr_valid is high the next cycle (latency 1).
  - wr_addr = base + 4*index.
  - Increment the accepted count.
  - After the last accept, go to DRAIN.
- Output register:
  - wr_valid and wr_data/wr_addr hold stable while wr_valid && !wr_ready.
  - When the register is drained and refilled in the same cycle, the new word is loaded with no bubble.
  - Throughput is 1 word/cycle when wr_ready is held high.
- DRAIN:
  - in_ready=0.
  - When wr_valid && wr_ready for the final word, pulse done for 1 cycle in the following cycle, then return to IDLE.
  - err and err_idx hold until the next start.
- start while busy is ignored.
- Encodings (bit fields MSB first):
  - B: 000101 | imm26.
  - CBZ: 10110100 | imm19 | Rt.
  - B_LT: 01010100 | imm19 | 01011.
  - ADDS: 10101011000 | Rm | 000000 | Rn | Rd.
  - SUBS: 11101011000 | Rm | 000000 | Rn | Rd.
  - ADDI: 1001000100 | imm12 | Rn | Rd.
  - LDUR / LDURB / STUR / STURB: 11111000010 / 00111000010 / 11111000000 / 00111000000, then | imm9 | 00 | Rn | Rt.
  - MOVK: 111100101 | hw | imm16 | Rd.
  - MOVZ: 110100101 | hw | imm16 | Rd.
- Range checks:
  - Signed ranges: imm19 in [-2^18, 2^18-1]; imm9 in [-256, 255].
  - Unsigned checks: ADDI requires in_imm[25:12]==0; MOVK/MOVZ require in_imm[25:16]==0.
  - B uses all 26 bits and always passes.
  - On a violation, the field is truncated to its low bits, the word is still written, and err is set.
  - err_idx is captured only on the first error of the job.
- An illegal op writes 32'h0000_0000 and flags err the same way.
- Address arithmetic wraps modulo 2^ADDR_W.

Test Plan:
- Job of 3 with base=0x100 and wr_ready=1: ADDI X1,X31,#5; ADDS X2,X1,X1; B #-2 → writes 0x910017E1@0x100, 0xAB010022@0x104, 0x17FFFFFE@0x108 on consecutive cycles; done pulses once; err=0.
- CBZ X3,#4 then B_LT #-1 → 0xB4000083, 0x54FFFFEB.
- LDUR X4,[X5,#-8], STURB X4,[X5,#255], MOVK X6,#0xBEEF,LSL 16 → 0xF85F80A4, 0x380FF0A4, 0xF2B7DDE6.
- wr_ready held low 3 cycles mid-job → wr_data/wr_addr stable, in_ready=0; no word lost or duplicated.
- Errors → ADDI with imm=4096 at index 1 → err=1, err_idx=1, word written with imm12=0. A later illegal op=13 → 0x00000000 written, err_idx stays 1. A new start clears err.
- num_instr=0 → done one cycle after start, no wr_valid. reset_n asserted mid-job → all outputs 0 asynchronously, FSM in IDLE.
